// File: rtl/coad_pkg.sv
// Shared decode constants: EXTOp one-hot selects, RV32I opcodes, IF/ID state encoding
// and the decoded bundle carried through the IF/ID main and skid registers.
package coad_pkg;

  // One-hot immediate-type selects, bit-identical to what the extension unit decodes
  localparam logic [5:0] EXT_NONE  = 6'b000000;
  localparam logic [5:0] EXT_ITYPE = 6'b010000;
  localparam logic [5:0] EXT_STYPE = 6'b001000;
  localparam logic [5:0] EXT_BTYPE = 6'b000100;
  localparam logic [5:0] EXT_JTYPE = 6'b000001;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] iimm;
    logic [11:0] simm;
    logic [11:0] bimm;
    logic [19:0] jimm;
    logic [5:0]  extop;
    logic        illegal;
  } id_bundle_t;

endpackage

// File: rtl/inst_field_decode.sv
// Combinational RV32I field slicer: register indices, raw immediate fields,
// one-hot EXTOp select and illegal-opcode flag.
module inst_field_decode
  import coad_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [11:0] o_iimm,
  output logic [11:0] o_simm,
  output logic [11:0] o_bimm,
  output logic [19:0] o_jimm,
  output logic [5:0]  o_extop,
  output logic        o_illegal
);

  assign o_rs1  = i_inst[19:15];
  assign o_rs2  = i_inst[24:20];
  assign o_rd   = i_inst[11:7];
  assign o_iimm = i_inst[31:20];
  assign o_simm = {i_inst[31:25], i_inst[11:7]};
  assign o_bimm = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8]};
  assign o_jimm = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21]};

  always_comb begin
    o_extop   = EXT_NONE;
    o_illegal = 1'b0;
    case (i_inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: o_extop = EXT_ITYPE;
      OP_STORE:                 o_extop = EXT_STYPE;
      OP_BRANCH:                o_extop = EXT_BTYPE;
      OP_JAL:                   o_extop = EXT_JTYPE;
      // Legal opcodes that carry no sign-extended immediate
      OP_REG, OP_LUI, OP_AUIPC: o_extop = EXT_NONE;
      default:                  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with a one-entry skid buffer: if_ready and id_valid are
// decoded straight from the state flops, and the decoded bundle is stored per beat.
module if_id_decode
  import coad_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [PC_W-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_inst,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [11:0]     iimm,
  output logic [11:0]     simm,
  output logic [11:0]     bimm,
  output logic [19:0]     jimm,
  output logic [5:0]      EXTOp,
  output logic            illegal
);

  state_e          r_state;
  state_e          w_state_nxt;
  id_bundle_t      r_main;
  id_bundle_t      r_skid;
  id_bundle_t      w_dec;
  logic [PC_W-1:0] r_main_pc;
  logic [PC_W-1:0] r_skid_pc;

  logic        w_accept;
  logic        w_fire;
  logic        w_load_main_in;
  logic        w_load_main_skid;
  logic        w_load_skid;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [11:0] w_iimm;
  logic [11:0] w_simm;
  logic [11:0] w_bimm;
  logic [19:0] w_jimm;
  logic [5:0]  w_extop;
  logic        w_illegal;

  inst_field_decode u_dec (
    .i_inst    (if_inst),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_rd      (w_rd),
    .o_iimm    (w_iimm),
    .o_simm    (w_simm),
    .o_bimm    (w_bimm),
    .o_jimm    (w_jimm),
    .o_extop   (w_extop),
    .o_illegal (w_illegal)
  );

  assign w_dec = '{inst: if_inst, rs1: w_rs1, rs2: w_rs2, rd: w_rd,
                   iimm: w_iimm, simm: w_simm, bimm: w_bimm, jimm: w_jimm,
                   extop: w_extop, illegal: w_illegal};

  assign if_ready = (r_state != ST_FULL);
  assign id_valid = (r_state != ST_EMPTY);
  assign w_accept = if_valid & if_ready;
  assign w_fire   = id_valid & id_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Flush wins over every transition; the skid is invalidated purely by leaving FULL.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end else if (w_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_fire) begin
            w_state_nxt      = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_main    <= '0;
      r_main_pc <= '0;
      r_skid    <= '0;
      r_skid_pc <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main    <= w_dec;
        r_main_pc <= if_pc;
      end else if (w_load_main_skid) begin
        r_main    <= r_skid;
        r_main_pc <= r_skid_pc;
      end
      if (w_load_skid) begin
        r_skid    <= w_dec;
        r_skid_pc <= if_pc;
      end
    end
  end

  assign id_pc   = r_main_pc;
  assign id_inst = r_main.inst;
  assign rs1     = r_main.rs1;
  assign rs2     = r_main.rs2;
  assign rd      = r_main.rd;
  assign iimm    = r_main.iimm;
  assign simm    = r_main.simm;
  assign bimm    = r_main.bimm;
  assign jimm    = r_main.jimm;
  assign EXTOp   = r_main.extop;
  assign illegal = r_main.illegal;

endmodule

// File: tb/tb_if_id_decode.sv
// Self-checking bench for if_id_decode: directed decode/handshake/flush/reset cases
// plus a random burst, with a FIFO scoreboard comparing every fired beat.
module tb_if_id_decode;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] iimm, simm, bimm;
  logic [19:0] jimm;
  logic [5:0]  EXTOp;
  logic        illegal;

  always #5 clk = ~clk;

  if_id_decode #(.PC_W(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .iimm     (iimm),
    .simm     (simm),
    .bimm     (bimm),
    .jimm     (jimm),
    .EXTOp    (EXTOp),
    .illegal  (illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } beat_t;

  beat_t       sb_q[$];
  beat_t       mon_e;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        rnd_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ref_extop(input logic [31:0] inst);
    case (inst[6:0])
      7'h13, 7'h03, 7'h67: ref_extop = 6'b010000;
      7'h23:               ref_extop = 6'b001000;
      7'h63:               ref_extop = 6'b000100;
      7'h6F:               ref_extop = 6'b000001;
      default:             ref_extop = 6'b000000;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] inst);
    case (inst[6:0])
      7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h37, 7'h17: ref_illegal = 1'b0;
      default: ref_illegal = 1'b1;
    endcase
  endfunction

  // Scoreboard: fire pops before accept pushes, since the output beat is the older one.
  always @(negedge clk) begin
    if (!rstn || flush) begin
      sb_q.delete();
    end else begin
      if (id_valid && id_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_spurious", {63'd0, id_valid}, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_pc",   id_pc,   mon_e.pc);
          check("sb_inst", id_inst, mon_e.inst);
          check("sb_rs1",  rs1,  mon_e.inst[19:15]);
          check("sb_rs2",  rs2,  mon_e.inst[24:20]);
          check("sb_rd",   rd,   mon_e.inst[11:7]);
          check("sb_iimm", iimm, mon_e.inst[31:20]);
          check("sb_simm", simm, {mon_e.inst[31:25], mon_e.inst[11:7]});
          check("sb_bimm", bimm, {mon_e.inst[31], mon_e.inst[7], mon_e.inst[30:25], mon_e.inst[11:8]});
          check("sb_jimm", jimm, {mon_e.inst[31], mon_e.inst[19:12], mon_e.inst[20], mon_e.inst[30:21]});
          check("sb_extop", EXTOp, ref_extop(mon_e.inst));
          check("sb_illegal", illegal, ref_illegal(mon_e.inst));
        end
      end
      if (if_valid && if_ready) sb_q.push_back('{if_pc, if_inst});
    end
  end

  // Holds the beat on the fetch side until accepted; returns at posedge+1 after the accept.
  task automatic send(input logic [31:0] pc, input logic [31:0] inst);
    logic acc;
    acc      = 1'b0;
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (if_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if_valid = 1'b0;
    if (!acc) check("send_timeout", {63'd0, acc}, 64'd1);
  endtask

  logic [31:0] t_inst[5]  = '{32'h00500093, 32'h0020A423, 32'hFE000EE3, 32'h008000EF, 32'h0000007F};
  logic [5:0]  t_extop[5] = '{6'b010000, 6'b001000, 6'b000100, 6'b000001, 6'b000000};
  logic        t_ill[5]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int unsigned t_sel[5]   = '{0, 1, 2, 3, 0};
  logic [19:0] t_imm[5]   = '{20'h005, 20'h008, 20'hFFE, 20'h00004, 20'h000};
  logic [6:0]  r_ops[10]  = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h37, 7'h17, 7'h7F};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [19:0] imm_got;
    logic [31:0] r;
    rstn     = 1'b0;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_pc    = '0;
    if_inst  = '0;
    id_ready = 1'b0;
    rnd_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_ready", if_ready, 1);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_pc",    id_pc,    0);
    check("rst_id_inst",  id_inst,  0);
    check("rst_extop",    EXTOp,    0);
    check("rst_illegal",  illegal,  0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed decode stream, back-to-back with id_ready held high
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(32'(i * 4), t_inst[i]);
      check("dir_valid",   id_valid, 1);
      check("dir_pc",      id_pc,    32'(i * 4));
      check("dir_extop",   EXTOp,    t_extop[i]);
      check("dir_illegal", illegal,  t_ill[i]);
      case (t_sel[i])
        0:       imm_got = {8'd0, iimm};
        1:       imm_got = {8'd0, simm};
        2:       imm_got = {8'd0, bimm};
        default: imm_got = jimm;
      endcase
      check("dir_imm", imm_got, t_imm[i]);
      if (i == 0) begin
        check("addi_rd", rd, 1);
        check("addi_rs1", rs1, 0);
      end
      if (i == 1) begin
        check("sw_rs1", rs1, 1);
        check("sw_rs2", rs2, 2);
      end
      if (i == 3) check("jal_rd", rd, 1);
    end
    @(posedge clk);
    #1;
    check("idle_valid", id_valid, 0);

    // Backpressure: fill main and skid, hold the third beat
    id_ready = 1'b0;
    send(32'h0, 32'h00100113);
    send(32'h4, 32'h00200193);
    check("bp_ready_low", if_ready, 0);
    check("bp_pc0", id_pc, 32'h0);
    fork
      send(32'h8, 32'h00300213);
      begin
        repeat (2) begin
          @(posedge clk);
          #1;
          check("bp_hold_ready", if_ready, 0);
          check("bp_hold_pc",    id_pc,    32'h0);
        end
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_rise", if_ready, 1);
        check("bp_pc4",        id_pc,    32'h4);
      end
    join
    check("bp_pc8", id_pc, 32'h8);
    @(posedge clk);
    #1;
    check("bp_drained", id_valid, 0);

    // Flush in FULL with a beat offered in the same cycle
    id_ready = 1'b0;
    send(32'h20, 32'h00100113);
    send(32'h24, 32'h00200193);
    flush    = 1'b1;
    if_valid = 1'b1;
    if_pc    = 32'h28;
    if_inst  = 32'h00300213;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    if_valid = 1'b0;
    check("flush_valid", id_valid, 0);
    check("flush_ready", if_ready, 1);
    id_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("flush_gone", id_valid, 0);
    end
    send(32'h30, 32'h00500093);
    check("post_flush_pc", id_pc, 32'h30);

    // Asynchronous reset mid-stream while in ONE
    id_ready = 1'b0;
    send(32'h40, 32'h008000EF);
    check("pre_rst_valid", id_valid, 1);
    #3;
    rstn = 1'b0;
    #1;
    check("arst_valid", id_valid, 0);
    check("arst_ready", if_ready, 1);
    check("arst_pc",    id_pc,    0);
    check("arst_inst",  id_inst,  0);
    check("arst_extop", EXTOp,    0);
    check("arst_jimm",  jimm,     0);
    check("arst_rd",    rd,       0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    id_ready = 1'b1;
    send(32'h50, 32'h0020A423);
    check("post_rst_valid", id_valid, 1);
    check("post_rst_pc",    id_pc,    32'h50);
    check("post_rst_extop", EXTOp,    6'b001000);

    // Random burst with random downstream backpressure
    fork
      begin
        for (int b = 0; b < 30; b++) begin
          r = $urandom();
          send(32'h1000 + 32'(b * 4), {r[31:7], r_ops[$urandom_range(0, 9)]});
        end
        rnd_done = 1'b1;
      end
      begin
        for (int c = 0; c < 2000 && !rnd_done; c++) begin
          @(posedge clk);
          #1;
          id_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    id_ready = 1'b1;
    for (int c = 0; c < 20 && sb_q.size() > 0; c++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", sb_q.size(), 0);
    check("drain_valid", id_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
